sa_multi_issue_controller: RTL

Multi-channel issue controller for the systolic-array compute path: buffers dispatched matrix instructions in an in-order queue and issues each one to one of `N_CH` systolic-array weight-load (WL) stages. The target channel is picked round-robin among free channels. An accumulator-hazard scoreboard keeps any instruction from issuing while another channel still has an in-flight instruction writing the same accumulator. It sits between the matrix dispatcher and the replicated systolic arrays, and supersedes the single-channel issue queue.

---
 rtl/sa_multi_issue_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sa_multi_issue_controller.sv
// In-order issue queue feeding N_CH systolic-array channels with an accumulator scoreboard.
// Define SA_DONE_BYPASS_EN to let done_i free a channel/hazard within the same cycle.
`timescale 1ns/1ps
module sa_multi_issue_controller #(
    parameter int N_SLOTS     = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int N_CH        = 2,
    parameter int N_ACC       = 4,
    localparam int ACC_W      = (N_ACC > 1) ? $clog2(N_ACC) : 1,
    localparam int UW         = $clog2(N_SLOTS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   dispatch_i,
    input  logic [INSTR_WIDTH-1:0] dispatched_instr_i,
    input  logic [ACC_W-1:0]       dispatched_acc_i,
    output logic                   issue_queue_full_o,
    output logic [UW-1:0]          issue_queue_usage_o,
    input  logic [N_CH-1:0]        wl_ready_i,
    input  logic [N_CH-1:0]        done_i,
    output logic [N_CH-1:0]        start_o,
    output logic [INSTR_WIDTH-1:0] issued_instr_o,
    output logic [ACC_W-1:0]       issued_acc_o,
    output logic [N_CH-1:0]        busy_o
);

    localparam int PW = $clog2(N_SLOTS);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [INSTR_WIDTH-1:0] instr_mem_q [N_SLOTS];
    logic [ACC_W-1:0]       acc_mem_q   [N_SLOTS];
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [UW-1:0]          cnt_q, cnt_d;
    logic [N_CH-1:0]        busy_q, busy_d;
    logic [ACC_W-1:0]       ch_acc_q [N_CH];
    logic [ACC_W-1:0]       ch_acc_d [N_CH];
    logic [CW-1:0]          rr_q, rr_d;

    logic            empty, full, push, issue, blocked, found;
    logic [ACC_W-1:0] head_acc;
    logic [N_CH-1:0] avail_busy, eligible;
    logic [CW-1:0]   sel;
    logic [CW:0]     cand;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == UW'(N_SLOTS));
    assign head_acc = acc_mem_q[rptr_q];

`ifdef SA_DONE_BYPASS_EN
    assign avail_busy = busy_q & ~done_i;
`else
    assign avail_busy = busy_q;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_SLOTS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Hazard check and cyclic search for the first eligible channel from rr_q
    always_comb begin
        blocked  = 1'b0;
        found    = 1'b0;
        sel      = '0;
        cand     = '0;
        eligible = wl_ready_i & ~avail_busy;
        for (int c = 0; c < N_CH; c++) begin
            if (avail_busy[c] && (ch_acc_q[c] == head_acc)) begin
                blocked = 1'b1;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, rr_q} + (CW+1)'(k);
            if (cand >= (CW+1)'(N_CH)) begin
                cand = cand - (CW+1)'(N_CH);
            end
            if (!found && eligible[cand[CW-1:0]]) begin
                found = 1'b1;
                sel   = cand[CW-1:0];
            end
        end
        issue   = !flush_i && !empty && !blocked && found;
        start_o = issue ? (N_CH'(1) << sel) : '0;
    end

    always_comb begin
        push     = dispatch_i && !full && !flush_i;
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        ch_acc_d = ch_acc_q;
        rr_d     = rr_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (issue) begin
                rptr_d = ptr_inc(rptr_q);
            end
            if (push && !issue) begin
                cnt_d = cnt_q + UW'(1);
            end else if (!push && issue) begin
                cnt_d = cnt_q - UW'(1);
            end
        end
        // A new issue outranks a completion on the same channel
        for (int c = 0; c < N_CH; c++) begin
            if (start_o[c]) begin
                busy_d[c]   = 1'b1;
                ch_acc_d[c] = head_acc;
            end else if (done_i[c]) begin
                busy_d[c] = 1'b0;
            end
        end
        if (issue) begin
            rr_d = (sel == CW'(N_CH - 1)) ? '0 : sel + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
            ch_acc_q <= '{default: '0};
            rr_q     <= '0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ch_acc_q <= ch_acc_d;
            rr_q     <= rr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wptr_q] <= dispatched_instr_i;
            acc_mem_q[wptr_q]   <= dispatched_acc_i;
        end
    end

    assign issue_queue_full_o  = full;
    assign issue_queue_usage_o = cnt_q;
    assign issued_instr_o      = empty ? '0 : instr_mem_q[rptr_q];
    assign issued_acc_o        = empty ? '0 : head_acc;
    assign busy_o              = busy_q;

endmodule
